// File: rtl/spy_pkg.sv
// Shared definitions for the path delay sampler: controller state encoding
// and default widths / settle length.
package spy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_REPORT  = 3'd5
  } spy_state_e;

  localparam int TRIAL_W_DEF       = 16;
  localparam int DLY_W_DEF         = 4;
  localparam int SETTLE_CYCLES_DEF = 8;

endpackage

// File: rtl/spy_capture_cell.sv
// Capture cell at the end of the chained delay path: one plain flop that
// samples path_result (no synchronizer; metastability here is the measured
// quantity) plus the compare against the expected polarity.
module spy_capture_cell #(
  parameter bit PATH_INVERTING = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic cap_en,
  input  logic path_result,
  input  logic path_input,
  output logic mismatch
);

  logic sample_d;
  logic sample_q;

  // Hold the sample except on the capture edge.
  always_comb begin
    sample_d = sample_q;
    if (cap_en) sample_d = path_result;
  end

  // The single capture flop; path_result enters the clock domain only here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample_q <= 1'b0;
    else     sample_q <= sample_d;
  end

  assign mismatch = sample_q ^ (path_input ^ PATH_INVERTING);

endmodule

// File: rtl/path_delay_sampler.sv
// Launch/capture controller for a chained delay path. Toggles path_input,
// samples path_result capture_delay+2 cycles after the launch edge, repeats
// for num_trials trials and reports the number of late samples through a
// valid/ready handshake.
// Optional build macro SPY_FIRST_FAIL_EN adds first_fail_idx/first_fail_seen.
module path_delay_sampler
  import spy_pkg::*;
#(
  parameter int TRIAL_W        = TRIAL_W_DEF,
  parameter int DLY_W          = DLY_W_DEF,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter bit PATH_INVERTING = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TRIAL_W-1:0] num_trials,
  input  logic [DLY_W-1:0]   capture_delay,
  output logic               path_input,
  input  logic               path_result,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [TRIAL_W-1:0] mismatch_count
`ifdef SPY_FIRST_FAIL_EN
  ,
  output logic [TRIAL_W-1:0] first_fail_idx,
  output logic               first_fail_seen
`endif
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  spy_state_e         state_d, state_q;
  logic               path_input_d, path_input_q;
  logic               busy_d, busy_q;
  logic               valid_d, valid_q;
  logic [TRIAL_W-1:0] count_d, count_q;
  logic [TRIAL_W-1:0] trials_d, trials_q;
  logic [TRIAL_W-1:0] idx_d, idx_q;
  logic [DLY_W-1:0]   cdly_d, cdly_q;
  logic [DLY_W-1:0]   dly_d, dly_q;
  logic [SET_W-1:0]   set_d, set_q;
`ifdef SPY_FIRST_FAIL_EN
  logic [TRIAL_W-1:0] ffi_d, ffi_q;
  logic               ffs_d, ffs_q;
`endif

  logic cap_en;
  logic mismatch;

  function automatic logic [TRIAL_W-1:0] sat_inc(input logic [TRIAL_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // The capture edge is the one that moves WAIT into CAPTURE.
  assign cap_en = (state_q == ST_WAIT) && (dly_q == '0);

  spy_capture_cell #(
    .PATH_INVERTING (PATH_INVERTING)
  ) u_capture (
    .clk         (clk),
    .rst         (rst),
    .cap_en      (cap_en),
    .path_result (path_result),
    .path_input  (path_input_q),
    .mismatch    (mismatch)
  );

  // Next-state and datapath updates for the launch/capture sequence.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    trials_d = trials_q;
    idx_d    = idx_q;
    cdly_d   = cdly_q;
    dly_d    = dly_q;
    set_d    = set_q;
`ifdef SPY_FIRST_FAIL_EN
    ffi_d    = ffi_q;
    ffs_d    = ffs_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          trials_d = num_trials;
          cdly_d   = capture_delay;
          count_d  = '0;
          idx_d    = '0;
`ifdef SPY_FIRST_FAIL_EN
          ffi_d    = '0;
          ffs_d    = 1'b0;
`endif
          state_d  = (num_trials == '0) ? ST_REPORT : ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        dly_d   = cdly_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dly_q == '0) state_d = ST_CAPTURE;
        else             dly_d   = dly_q - 1'b1;
      end
      ST_CAPTURE: begin
        if (mismatch) begin
          count_d = sat_inc(count_q);
`ifdef SPY_FIRST_FAIL_EN
          if (!ffs_q) begin
            ffi_d = idx_q;
            ffs_d = 1'b1;
          end
`endif
        end
        idx_d   = idx_q + 1'b1;
        set_d   = SETTLE_LAST;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (set_q == '0) state_d = (idx_q < trials_q) ? ST_LAUNCH : ST_REPORT;
        else             set_d   = set_q - 1'b1;
      end
      ST_REPORT: begin
        if (valid_q && result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Launch edge: path_input flips on the edge that enters LAUNCH.
    path_input_d = (state_d == ST_LAUNCH) ? ~path_input_q : path_input_q;
    busy_d       = (state_d != ST_IDLE) && (state_d != ST_REPORT);
    valid_d      = (state_d == ST_REPORT);
  end

  // Control and counter registers; everything returns to idle on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      path_input_q <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      count_q      <= '0;
      trials_q     <= '0;
      idx_q        <= '0;
      cdly_q       <= '0;
      dly_q        <= '0;
      set_q        <= '0;
`ifdef SPY_FIRST_FAIL_EN
      ffi_q        <= '0;
      ffs_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      path_input_q <= path_input_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      trials_q     <= trials_d;
      idx_q        <= idx_d;
      cdly_q       <= cdly_d;
      dly_q        <= dly_d;
      set_q        <= set_d;
`ifdef SPY_FIRST_FAIL_EN
      ffi_q        <= ffi_d;
      ffs_q        <= ffs_d;
`endif
    end
  end

  assign path_input     = path_input_q;
  assign busy           = busy_q;
  assign result_valid   = valid_q;
  assign mismatch_count = count_q;
`ifdef SPY_FIRST_FAIL_EN
  assign first_fail_idx  = ffi_q;
  assign first_fail_seen = ffs_q;
`endif

endmodule

// File: tb/tb_path_delay_sampler.sv
// Testbench for path_delay_sampler: behavioural transport-delay path model,
// scoreboard queue filled by the stimulus, monitor popping on result_valid.
module tb_path_delay_sampler;

  localparam int TW  = 16;
  localparam int DW  = 4;
  localparam int PER = 10;
  localparam int SET = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] num_trials;
  logic [DW-1:0] capture_delay;
  logic          path_input;
  logic          path_result;
  logic          busy;
  logic          result_valid;
  logic          result_ready;
  logic [TW-1:0] mismatch_count;
`ifdef SPY_FIRST_FAIL_EN
  logic [TW-1:0] first_fail_idx;
  logic          first_fail_seen;
`endif

  path_delay_sampler dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_trials     (num_trials),
    .capture_delay  (capture_delay),
    .path_input     (path_input),
    .path_result    (path_result),
    .busy           (busy),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .mismatch_count (mismatch_count)
`ifdef SPY_FIRST_FAIL_EN
    ,
    .first_fail_idx  (first_fail_idx),
    .first_fail_seen (first_fail_seen)
`endif
  );

  always #(PER/2) clk = ~clk;

  // ---------------- path model ----------------
  int   dly_ns     = 3;
  int   fail_trial = -1;
  int   run_base   = 0;
  int   launch_cnt = 0;
  logic delayed    = 1'b0;

  always @(path_input) begin
    launch_cnt = launch_cnt + 1;
    fork
      begin
        automatic logic v = path_input;
        automatic int   d = dly_ns;
        #(d);
        delayed = v;
      end
    join_none
  end

  // An injected fault inverts the path output for one chosen trial.
  assign path_result = delayed ^ ((fail_trial >= 0) && (launch_cnt - run_base - 1 == fail_trial));

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [TW-1:0] cnt;
    logic [TW-1:0] ffi;
    logic          ffs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A trial is late when the path delay (dclk whole periods plus skew) is not
  // shorter than the capture window of cd+2 cycles; a faulted trial flips.
  function automatic exp_t model(input int n, input int cd, input int dclk, input int ft);
    exp_t e;
    e.cnt = '0;
    e.ffi = '0;
    e.ffs = 1'b0;
    for (int t = 0; t < n; t++) begin
      if ((dclk >= cd + 2) != (t == ft)) begin
        if (e.cnt != 16'hFFFF) e.cnt = e.cnt + 1'b1;
        if (!e.ffs) begin
          e.ffs = 1'b1;
          e.ffi = TW'(t);
        end
      end
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit in_rep = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      in_rep = 1'b0;
    end else if (result_valid && !in_rep) begin
      exp_t e;
      in_rep = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("mismatch_count", 32'(mismatch_count), 32'(e.cnt));
`ifdef SPY_FIRST_FAIL_EN
        chk("first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
        chk("first_fail_seen", 32'(first_fail_seen), 32'(e.ffs));
`endif
      end
    end else if (!result_valid) begin
      in_rep = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  // Issues one run and returns at the first negedge showing result_valid.
  task automatic run(input int n, input int cd, input int dclk, input int ft, output int cycles);
    dly_ns     = dclk * PER + 3;
    fail_trial = ft;
    run_base   = launch_cnt;
    sb.push_back(model(n, cd, dclk, ft));
    @(negedge clk);
    num_trials    = TW'(n);
    capture_delay = DW'(cd);
    start         = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!result_valid && cycles < 5000) begin
      @(negedge clk);
      cycles++;
    end
    if (!result_valid) chk("run_timeout", 32'd0, 32'd1);
  endtask

  function automatic int period(input int cd);
    return 1 + (cd + 1) + 1 + SET;
  endfunction

  initial begin
    int   cyc;
    int   n, cd, d;
    logic pin;
    exp_t e;

    rst           = 1'b1;
    start         = 1'b0;
    num_trials    = '0;
    capture_delay = '0;
    result_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_path_input", 32'(path_input), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(result_valid), 32'd0);
    chk("reset_count", 32'(mismatch_count), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-delay path: every sample sees the new value.
    run(10, 2, 0, -1, cyc);
    chk("zero_dly_latency", 32'(cyc), 32'(1 + 10 * period(2)));
    chk("zero_dly_toggles", 32'(launch_cnt - run_base), 32'd10);
    @(negedge clk);
    chk("handshake_clears_valid", 32'(result_valid), 32'd0);

    // Five-period path: too late for capture_delay=1, in time for 7.
    run(20, 1, 5, -1, cyc);
    chk("slow_short_latency", 32'(cyc), 32'(1 + 20 * period(1)));
    @(negedge clk);
    run(20, 7, 5, -1, cyc);
    chk("slow_long_latency", 32'(cyc), 32'(1 + 20 * period(7)));
    @(negedge clk);

    // Zero trials: immediate report, no launch.
    pin = path_input;
    run(0, 3, 0, -1, cyc);
    chk("zero_trials_latency", 32'(cyc), 32'd1);
    chk("zero_trials_path_input", 32'(path_input), 32'(pin));
    chk("zero_trials_toggles", 32'(launch_cnt - run_base), 32'd0);
    @(negedge clk);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      n  = $urandom_range(12, 1);
      cd = $urandom_range(15, 0);
      d  = $urandom_range(9, 0);
      run(n, cd, d, -1, cyc);
      chk("rand_latency", 32'(cyc), 32'(1 + n * period(cd)));
      chk("rand_toggles", 32'(launch_cnt - run_base), 32'(n));
      @(negedge clk);
    end

    // Single faulted trial (index 4 of 8).
    run(8, 3, 0, 4, cyc);
    @(negedge clk);
    fail_trial = -1;

    // Backpressure: result held, extra starts ignored.
    result_ready = 1'b0;
    e = model(5, 0, 9, -1);
    run(5, 0, 9, -1, cyc);
    pin = path_input;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start = (i % 7 == 3);
      chk("bp_valid", 32'(result_valid), 32'd1);
      chk("bp_count", 32'(mismatch_count), 32'(e.cnt));
    end
    result_ready = 1'b1;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bp_release_valid", 32'(result_valid), 32'd0);
    repeat (5) @(negedge clk);
    chk("bp_no_restart_busy", 32'(busy), 32'd0);
    chk("bp_no_restart_valid", 32'(result_valid), 32'd0);
    chk("bp_no_restart_path", 32'(path_input), 32'(pin));

    // Reset in the middle of trial 3's WAIT on an always-late path.
    dly_ns   = 9 * PER + 3;
    run_base = launch_cnt;
    @(negedge clk);
    num_trials    = 16'd8;
    capture_delay = 4'd5;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while ((launch_cnt - run_base) < 4 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reset_reached_trial3", 32'(launch_cnt - run_base), 32'd4);
    @(negedge clk);
    chk("mid_reset_partial_count", 32'(mismatch_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_path_input", 32'(path_input), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_valid", 32'(result_valid), 32'd0);
    chk("async_rst_count", 32'(mismatch_count), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_reset_idle_valid", 32'(result_valid), 32'd0);
    run(6, 2, 1, -1, cyc);
    chk("post_reset_latency", 32'(cyc), 32'(1 + 6 * period(2)));
    @(negedge clk);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
